// File: rtl/icache_ctrl_pkg.sv
// Types and constants shared by the instruction-cache miss controller.
// No logic here; the bus encodings mirror the sys_defs macros.
// Line offset is fixed at 3 bits (8-byte lines).
`include "sys_defs.svh"

package icache_ctrl_pkg;

  localparam logic [1:0] BUS_NONE = `BUS_NONE;
  localparam logic [1:0] BUS_LOAD = `BUS_LOAD;

  localparam int LINE_OFS  = 3;
  localparam int MEM_TAG_W = 4;
  localparam int PF_CNT_W  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DEMAND,
    ST_PREFETCH
  } state_t;

  // Line-aligned base of a byte address.
  function automatic logic [63:0] line_base(input logic [63:0] a);
    return {a[63:LINE_OFS], {LINE_OFS{1'b0}}};
  endfunction

endpackage

// File: rtl/icache_mshr.sv
// Outstanding-fill table: allocates by memory tag, matches/frees on returning data, detects duplicate lines.
// Latency: match, probe and full are combinational; allocate/free take effect at the next posedge.
// Backpressure: full is asserted while every entry is valid as of cycle start; allocations are then ignored.
module icache_mshr
  import icache_ctrl_pkg::*;
#(
  parameter int IDX_BITS = 7,
  parameter int TAG_BITS = 54,
  parameter int MAX_OUT  = 4
)(
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         alloc_en,
  input  logic [MEM_TAG_W-1:0]         alloc_mem_tag,
  input  logic [IDX_BITS-1:0]          alloc_idx,
  input  logic [TAG_BITS-1:0]          alloc_tag,
  input  logic [MEM_TAG_W-1:0]         done_mem_tag,
  output logic                         done_hit,
  output logic [IDX_BITS-1:0]          done_idx,
  output logic [TAG_BITS-1:0]          done_tag,
  input  logic [IDX_BITS+TAG_BITS-1:0] probe_line,
  output logic                         probe_hit,
  output logic                         full
);

  localparam int SEL_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

  logic [MAX_OUT-1:0]   ent_vld;
  logic [MEM_TAG_W-1:0] ent_mtag [MAX_OUT];
  logic [IDX_BITS-1:0]  ent_idx  [MAX_OUT];
  logic [TAG_BITS-1:0]  ent_tag  [MAX_OUT];

  logic             free_fnd;
  logic [SEL_W-1:0] free_sel;
  logic [SEL_W-1:0] done_sel;

  // Lowest free entry, judged on start-of-cycle state so a same-cycle free is not reused.
  always_comb begin
    free_fnd = 1'b0;
    free_sel = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (!free_fnd && !ent_vld[i]) begin
        free_fnd = 1'b1;
        free_sel = SEL_W'(i);
      end
    end
  end

  assign full = !free_fnd;

  // Returning memory tag lookup; tag 0 never matches.
  always_comb begin
    done_hit = 1'b0;
    done_sel = '0;
    done_idx = '0;
    done_tag = '0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (!done_hit && ent_vld[i] && (done_mem_tag != '0) && (ent_mtag[i] == done_mem_tag)) begin
        done_hit = 1'b1;
        done_sel = SEL_W'(i);
        done_idx = ent_idx[i];
        done_tag = ent_tag[i];
      end
    end
  end

  // Line already in flight, used to suppress duplicate demand fills.
  always_comb begin
    probe_hit = 1'b0;
    for (int i = 0; i < MAX_OUT; i++) begin
      if (ent_vld[i] && ({ent_tag[i], ent_idx[i]} == probe_line)) begin
        probe_hit = 1'b1;
      end
    end
  end

  // Valid bits: free on completion, set on allocation; the two never touch the same entry.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ent_vld <= '0;
    end else begin
      if (done_hit) begin
        ent_vld[done_sel] <= 1'b0;
      end
      if (alloc_en && free_fnd) begin
        ent_vld[free_sel] <= 1'b1;
      end
    end
  end

  // Entry payload; only meaningful while the valid bit is set, so no reset needed.
  always_ff @(posedge clock) begin
    if (alloc_en && free_fnd) begin
      ent_mtag[free_sel] <= alloc_mem_tag;
      ent_idx[free_sel]  <= alloc_idx;
      ent_tag[free_sel]  <= alloc_tag;
    end
  end

endmodule

// File: rtl/sys_defs.svh
// Shared system definitions: cache geometry and memory bus command encodings.
// Included by any file that needs the raw macros; guarded against re-inclusion.
// The ICACHE_* macros describe a 128-line direct-mapped cache of 8-byte lines.
`ifndef SYS_DEFS_SVH
`define SYS_DEFS_SVH

`define ICACHE_LINES    128
`define ICACHE_IDX_BITS 7
`define ICACHE_TAG_BITS (64-3-`ICACHE_IDX_BITS)

`define BUS_NONE 2'h0
`define BUS_LOAD 2'h1

`endif

// File: rtl/icache_ctrl.sv
// Instruction-cache miss controller: lookup passthrough, demand line fill, next-line prefetch, fill writeback.
// Latency: hit 0 cycles; miss to BUS_LOAD >= 1 cycle; fill data written into the cache in its arrival cycle.
// Backpressure: retries rejected requests every cycle; holds BUS_NONE while the fill table is full.
`include "sys_defs.svh"

module icache_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int IDX_BITS = `ICACHE_IDX_BITS,
  parameter int TAG_BITS = `ICACHE_TAG_BITS,
  parameter int MAX_OUT  = 4,
  parameter int PF_LINES = 2
)(
  input  logic                 clock,
  input  logic                 reset,
  input  logic [63:0]          proc2Icache_addr,
  output logic [63:0]          Icache_data_out,
  output logic                 Icache_valid_out,
  output logic [IDX_BITS-1:0]  rd1_idx,
  output logic [TAG_BITS-1:0]  rd1_tag,
  input  logic [63:0]          cachemem_data,
  input  logic                 cachemem_valid,
  output logic                 wr1_en,
  output logic [IDX_BITS-1:0]  wr1_idx,
  output logic [TAG_BITS-1:0]  wr1_tag,
  output logic [63:0]          wr1_data,
  output logic [1:0]           proc2Imem_command,
  output logic [63:0]          proc2Imem_addr,
  input  logic [3:0]           Imem2proc_response,
  input  logic [3:0]           Imem2proc_tag,
  input  logic [63:0]          Imem2proc_data
);

  localparam int LINE_W = IDX_BITS + TAG_BITS;

  state_t              state;
  logic [63:0]         req_addr;
  logic [PF_CNT_W-1:0] pf_cnt;
  logic [PF_CNT_W-1:0] pf_nxt;

  logic [LINE_W-1:0]   fetch_line;
  logic [LINE_W-1:0]   req_line;
  logic                miss;
  logic                dup;
  logic                new_miss;
  logic                issue;
  logic                accept;
  logic                tbl_full;
  logic                tbl_probe_hit;
  logic                tbl_done_hit;
  logic [LINE_OFS-1:0] unused_ofs;

  // Lookup is pure passthrough to the cache memory.
  assign rd1_idx          = proc2Icache_addr[LINE_OFS +: IDX_BITS];
  assign rd1_tag          = proc2Icache_addr[LINE_OFS+IDX_BITS +: TAG_BITS];
  assign Icache_data_out  = cachemem_data;
  assign Icache_valid_out = cachemem_valid;
  assign unused_ofs       = proc2Icache_addr[LINE_OFS-1:0];

  assign fetch_line = proc2Icache_addr[63:LINE_OFS];
  assign req_line   = req_addr[63:LINE_OFS];
  assign miss       = !cachemem_valid;
  // req_addr only names a live request outside IDLE; afterwards it is just the next prefetch cursor.
  assign dup        = tbl_probe_hit || ((state != ST_IDLE) && (fetch_line == req_line));
  assign new_miss   = miss && !dup;

  // Command is decided in-cycle: a full table or a fresh demand miss must suppress the issue immediately.
  assign issue             = reset && (state != ST_IDLE) && !tbl_full && !new_miss;
  assign accept            = issue && (Imem2proc_response != '0);
  assign proc2Imem_command = issue ? BUS_LOAD : BUS_NONE;
  assign proc2Imem_addr    = reset ? req_addr : '0;

  assign wr1_en   = reset && tbl_done_hit;
  assign wr1_data = Imem2proc_data;

  icache_mshr #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS),
    .MAX_OUT  (MAX_OUT)
  ) u_mshr (
    .clock         (clock),
    .reset         (reset),
    .alloc_en      (accept),
    .alloc_mem_tag (Imem2proc_response),
    .alloc_idx     (req_addr[LINE_OFS +: IDX_BITS]),
    .alloc_tag     (req_addr[LINE_OFS+IDX_BITS +: TAG_BITS]),
    .done_mem_tag  (Imem2proc_tag),
    .done_hit      (tbl_done_hit),
    .done_idx      (wr1_idx),
    .done_tag      (wr1_tag),
    .probe_line    (fetch_line),
    .probe_hit     (tbl_probe_hit),
    .full          (tbl_full)
  );

  assign pf_nxt = pf_cnt + PF_CNT_W'(1);

  // Request sequencer: demand fill first, then PF_LINES sequential prefetches; a new demand miss preempts.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state    <= ST_IDLE;
      req_addr <= '0;
      pf_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (new_miss) begin
            req_addr <= line_base(proc2Icache_addr);
            state    <= ST_DEMAND;
          end
        end
        ST_DEMAND: begin
          if (new_miss) begin
            state <= ST_IDLE;
          end else if (accept) begin
            req_addr <= req_addr + 64'd8;
            pf_cnt   <= '0;
            state    <= (PF_LINES == 0) ? ST_IDLE : ST_PREFETCH;
          end
        end
        ST_PREFETCH: begin
          if (new_miss) begin
            state <= ST_IDLE;
          end else if (accept) begin
            req_addr <= req_addr + 64'd8;
            pf_cnt   <= pf_nxt;
            if (pf_nxt == PF_CNT_W'(PF_LINES)) begin
              state <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_icache_ctrl.sv
// Directed bench for icache_ctrl with a small behavioural cache memory on the rd1/wr1 ports.
// Inputs change 1 time unit after posedge; outputs are compared 2 units later, mid-cycle.
// Each step lists the expected bus/fill behaviour worked out by hand from the protocol.
module tb_icache_ctrl;
  import icache_ctrl_pkg::*;

  localparam int IDX_BITS = 7;
  localparam int TAG_BITS = 54;

  logic                clock;
  logic                reset;
  logic [63:0]         proc2Icache_addr;
  logic [63:0]         Icache_data_out;
  logic                Icache_valid_out;
  logic [IDX_BITS-1:0] rd1_idx;
  logic [TAG_BITS-1:0] rd1_tag;
  logic [63:0]         cachemem_data;
  logic                cachemem_valid;
  logic                wr1_en;
  logic [IDX_BITS-1:0] wr1_idx;
  logic [TAG_BITS-1:0] wr1_tag;
  logic [63:0]         wr1_data;
  logic [1:0]          proc2Imem_command;
  logic [63:0]         proc2Imem_addr;
  logic [3:0]          Imem2proc_response;
  logic [3:0]          Imem2proc_tag;
  logic [63:0]         Imem2proc_data;

  int errors = 0;
  int checks = 0;
  int lat;

  icache_ctrl #(
    .IDX_BITS (IDX_BITS),
    .TAG_BITS (TAG_BITS),
    .MAX_OUT  (4),
    .PF_LINES (2)
  ) dut (
    .clock              (clock),
    .reset              (reset),
    .proc2Icache_addr   (proc2Icache_addr),
    .Icache_data_out    (Icache_data_out),
    .Icache_valid_out   (Icache_valid_out),
    .rd1_idx            (rd1_idx),
    .rd1_tag            (rd1_tag),
    .cachemem_data      (cachemem_data),
    .cachemem_valid     (cachemem_valid),
    .wr1_en             (wr1_en),
    .wr1_idx            (wr1_idx),
    .wr1_tag            (wr1_tag),
    .wr1_data           (wr1_data),
    .proc2Imem_command  (proc2Imem_command),
    .proc2Imem_addr     (proc2Imem_addr),
    .Imem2proc_response (Imem2proc_response),
    .Imem2proc_tag      (Imem2proc_tag),
    .Imem2proc_data     (Imem2proc_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Behavioural 128-line cache memory.
  logic                cm_vld [128];
  logic [TAG_BITS-1:0] cm_tag [128];
  logic [63:0]         cm_dat [128];

  assign cachemem_valid = cm_vld[rd1_idx] && (cm_tag[rd1_idx] == rd1_tag);
  assign cachemem_data  = cm_dat[rd1_idx];

  always @(posedge clock) begin
    if (wr1_en) begin
      cm_vld[wr1_idx] <= 1'b1;
      cm_tag[wr1_idx] <= wr1_tag;
      cm_dat[wr1_idx] <= wr1_data;
    end
  end

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 128; i++) begin
      cm_vld[i] = 1'b0;
      cm_tag[i] = '0;
      cm_dat[i] = '0;
    end
    reset              = 1'b0;
    proc2Icache_addr   = 64'h0;
    Imem2proc_response = 4'h0;
    Imem2proc_tag      = 4'h0;
    Imem2proc_data     = 64'h0;

    // Reset state
    tick(); tick(); settle();
    check("rst_cmd",    64'(proc2Imem_command), 64'(BUS_NONE));
    check("rst_addr",   proc2Imem_addr, 64'h0);
    check("rst_wr1_en", 64'(wr1_en), 64'h0);
    check("rst_hit",    64'(Icache_valid_out), 64'h0);

    // Cold miss at 0x1000: idx 0, tag 4; demand then two prefetches
    tick(); reset = 1'b1; proc2Icache_addr = 64'h1000; settle();
    check("cold_idle_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    check("cold_rd1_idx",  64'(rd1_idx), 64'h0);
    check("cold_rd1_tag",  64'(rd1_tag), 64'h4);
    tick(); Imem2proc_response = 4'd3; settle();
    check("cold_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
    check("cold_addr", proc2Imem_addr, 64'h1000);
    tick(); Imem2proc_response = 4'd1; settle();
    check("pf1_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
    check("pf1_addr", proc2Imem_addr, 64'h1008);
    tick(); Imem2proc_response = 4'd2; settle();
    check("pf2_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
    check("pf2_addr", proc2Imem_addr, 64'h1010);
    tick(); Imem2proc_response = 4'd0; settle();
    check("pf_done_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    repeat (6) tick();
    Imem2proc_tag = 4'd3; Imem2proc_data = 64'hDEADBEEF; settle();
    check("fill3_en",   64'(wr1_en), 64'h1);
    check("fill3_idx",  64'(wr1_idx), 64'h0);
    check("fill3_tag",  64'(wr1_tag), 64'h4);
    check("fill3_data", wr1_data, 64'hDEADBEEF);
    check("fill3_cmd",  64'(proc2Imem_command), 64'(BUS_NONE));
    tick(); Imem2proc_tag = 4'd0; settle();
    check("hit_valid", 64'(Icache_valid_out), 64'h1);
    check("hit_data",  Icache_data_out, 64'hDEADBEEF);
    check("hit_wr1",   64'(wr1_en), 64'h0);

    // Rejected requests at 0x2000 (idx 0, tag 8) are retried with the address held
    tick(); proc2Icache_addr = 64'h2000; settle();
    check("rej_idle_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    for (int k = 0; k < 5; k++) begin
      tick(); Imem2proc_response = 4'd0; settle();
      check("rej_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
      check("rej_addr", proc2Imem_addr, 64'h2000);
    end
    tick(); Imem2proc_response = 4'd5; settle();
    check("rej_acc_addr", proc2Imem_addr, 64'h2000);
    check("rej_acc_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
    tick(); Imem2proc_response = 4'd7; settle();
    check("pf3_addr", proc2Imem_addr, 64'h2008);
    check("pf3_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
    // Table now holds tags 5,1,2,7: prefetch of 0x2010 must stall
    tick(); Imem2proc_response = 4'd0; settle();
    check("full_pf_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));

    // New miss at 0x301C (line 0x3018, idx 3, tag 12) while full
    tick(); proc2Icache_addr = 64'h301C; settle();
    check("abort_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    check("abort_idx", 64'(rd1_idx), 64'h3);
    tick(); settle();
    check("full_idle_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    tick(); Imem2proc_tag = 4'd1; Imem2proc_data = 64'h1111_2222_3333_4444; settle();
    check("full_dem_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    check("fill1_en",     64'(wr1_en), 64'h1);
    check("fill1_idx",    64'(wr1_idx), 64'h1);
    check("fill1_tag",    64'(wr1_tag), 64'h4);
    check("fill1_data",   wr1_data, 64'h1111_2222_3333_4444);
    // Freed entry lets the demand issue; completion tag 5 and acceptance tag 6 together
    tick(); Imem2proc_tag = 4'd5; Imem2proc_data = 64'h5555_6666_7777_8888; Imem2proc_response = 4'd6; settle();
    check("same_cmd",   64'(proc2Imem_command), 64'(BUS_LOAD));
    check("same_addr",  proc2Imem_addr, 64'h3018);
    check("fill5_en",   64'(wr1_en), 64'h1);
    check("fill5_idx",  64'(wr1_idx), 64'h0);
    check("fill5_tag",  64'(wr1_tag), 64'h8);
    check("fill5_data", wr1_data, 64'h5555_6666_7777_8888);
    tick(); Imem2proc_tag = 4'd0; Imem2proc_response = 4'd0; settle();
    check("pf4_cmd",  64'(proc2Imem_command), 64'(BUS_LOAD));
    check("pf4_addr", proc2Imem_addr, 64'h3020);

    // Redirect to 0x8000 during prefetch
    tick(); proc2Icache_addr = 64'h8000; settle();
    check("redir_abort_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    lat = 0;
    while ((proc2Imem_command != BUS_LOAD) && (lat < 4)) begin
      tick(); settle();
      lat++;
    end
    check("redir_lat_ok", 64'((lat >= 1) && (lat <= 2)), 64'h1);
    check("redir_addr",   proc2Imem_addr, 64'h8000);
    Imem2proc_response = 4'd9;
    tick(); Imem2proc_response = 4'd0; Imem2proc_tag = 4'd6; Imem2proc_data = 64'hAAAA_0000_BBBB_0006; settle();
    check("fill6_idx",  64'(wr1_idx), 64'h3);
    check("fill6_tag",  64'(wr1_tag), 64'hC);
    check("fill6_data", wr1_data, 64'hAAAA_0000_BBBB_0006);
    check("full2_cmd",  64'(proc2Imem_command), 64'(BUS_NONE));
    tick(); Imem2proc_tag = 4'd7; Imem2proc_data = 64'hAAAA_0000_BBBB_0007; settle();
    check("fill7_idx", 64'(wr1_idx), 64'h1);
    check("fill7_tag", 64'(wr1_tag), 64'h8);
    check("pf5_cmd",   64'(proc2Imem_command), 64'(BUS_LOAD));
    check("pf5_addr",  proc2Imem_addr, 64'h8008);

    // Reset with tags 9 and 2 still outstanding
    tick(); Imem2proc_tag = 4'd0; reset = 1'b0; settle();
    tick(); Imem2proc_tag = 4'd9; Imem2proc_data = 64'h9999; settle();
    check("rst9_wr1_en", 64'(wr1_en), 64'h0);
    check("rst9_cmd",    64'(proc2Imem_command), 64'(BUS_NONE));
    check("rst9_addr",   proc2Imem_addr, 64'h0);
    tick(); reset = 1'b1; proc2Icache_addr = 64'h301C; Imem2proc_tag = 4'd2; Imem2proc_data = 64'h2222; settle();
    check("rst2_wr1_en", 64'(wr1_en), 64'h0);
    check("rst2_cmd",    64'(proc2Imem_command), 64'(BUS_NONE));
    check("rst2_addr",   proc2Imem_addr, 64'h0);
    check("rst2_hit",    64'(Icache_valid_out), 64'h1);
    tick(); Imem2proc_tag = 4'd0; settle();
    check("post_rst_cmd", 64'(proc2Imem_command), 64'(BUS_NONE));
    check("post_rst_wr1", 64'(wr1_en), 64'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/icache_ctrl.md
# icache_ctrl

Instruction-cache miss controller that sits between the fetch stage and the 128x64 instruction cache memory. It performs the cache lookup on behalf of fetch and issues line fills to instruction memory over the tagged memory bus. It tracks up to MAX_OUT outstanding fills and writes returned data into the cache memory write port. After each demand miss it runs a sequential next-line prefetch.

## Interface
- IDX_BITS, default `ICACHE_IDX_BITS` (7): cache index width
- TAG_BITS, default `ICACHE_TAG_BITS` (54): cache tag width, 64-3-IDX_BITS
- MAX_OUT, default 4: outstanding-fill table entries
- PF_LINES, default 2: lines prefetched after each accepted demand fill (0 disables prefetch)

Ports:
- clock  in  1  sole clock; all state updates on posedge
- reset  in  1  synchronous, active-low: state clears on a posedge where reset==0
- proc2Icache_addr  in  64  fetch PC; line = addr[63:3]
- Icache_data_out  out  64  instruction line; equals cachemem_data
- Icache_valid_out  out  1  hit; equals cachemem_valid
- rd1_idx  out  IDX_BITS  addr[3+IDX_BITS-1:3]
- rd1_tag  out  TAG_BITS  addr[63:3+IDX_BITS]
- cachemem_data  in  64  cache read data
- cachemem_valid  in  1  cache hit indication
- wr1_en  out  1  cache fill strobe
- wr1_idx  out  IDX_BITS  fill index
- wr1_tag  out  TAG_BITS  fill tag
- wr1_data  out  64  fill data
- proc2Imem_command  out  2  BUS_NONE / BUS_LOAD
- proc2Imem_addr  out  64  line address, low 3 bits zero
- Imem2proc_response  in  4  nonzero = request accepted, with its tag; 0 = rejected
- Imem2proc_tag  in  4  nonzero = data for that tag on this cycle
- Imem2proc_data  in  64  fill data

## Operation
- Lookup path is combinational. Hit latency is 0 cycles.
- Miss: cachemem_valid==0. A miss is a duplicate if its line matches a valid table entry or req_addr; duplicates never issue.
- FSM IDLE / DEMAND / PREFETCH:
  - IDLE: on a non-duplicate miss, load req_addr = {addr[63:3],3'b0} and go to DEMAND.
  - DEMAND: drive BUS_LOAD to req_addr, but hold BUS_NONE while the table is full.
    - Accept (response!=0): allocate an entry {tag=response, idx, cache tag}. Then req_addr += 8, pf_cnt = 0, and go to PREFETCH, or to IDLE if PF_LINES==0.
    - Reject: retry next cycle.
    - Fetch moves to a different missing line before acceptance: drop the request and go to IDLE.
  - PREFETCH: same issue rule as DEMAND. Each accept increments pf_cnt and adds 8 to req_addr. At pf_cnt==PF_LINES, go to IDLE.
    - Abort to IDLE with no issue that cycle if a non-duplicate demand miss appears.
    - Prefetch does not check the cache, so a refill of an already-present line is legal.
- Completion: Imem2proc_tag matches a valid entry. Drive wr1_en=1 with the entry's idx/tag and Imem2proc_data in the same cycle, and free the entry at that edge.
  - Tags 0, or tags matching no entry, are ignored.
- Allocation uses the lowest free entry as of cycle start. An entry freed this cycle is reusable next cycle.
- Address arithmetic is 64-bit and wraps modulo 2^64.

## Timing
- Reset values: state IDLE, table all invalid, proc2Imem_command=BUS_NONE, proc2Imem_addr=0, wr1_en=0, pf_cnt=0, req_addr=0.
- Miss seen in cycle t → BUS_LOAD in cycle t+1 at the earliest.
- Fill data in cycle d → wr1_en in cycle d → hit visible in cycle d+1.
- Acceptance and completion in the same cycle are independent and both occur.
- Reset mid-operation: all entries are dropped. Responses arriving afterwards match nothing and produce no write.
- At most one issue and one fill per cycle.

## Structure
- BUS_NONE/BUS_LOAD encodings and the ICACHE_IDX_BITS/ICACHE_TAG_BITS/ICACHE_LINES macros belong in the shared sys_defs header.
- One sub-module: icache_mshr, the MAX_OUT-entry table. It provides allocate, tag match/free, line-match for duplicate detection, and a full flag.

## Test plan
- Cold miss at 0x1000, response=3, tag 3 data 0xDEADBEEF after 10 cycles → one LOAD at 0x1000. Then prefetch LOADs at 0x1008 and 0x1010. wr1_en with idx=0x00 in the data cycle, hit the next cycle.
- Response 0 for 5 cycles → proc2Imem_addr held constant, BUS_LOAD reasserted each cycle, no entry allocated.
- MAX_OUT=4 entries outstanding, then a new miss → command stays BUS_NONE until a completion frees an entry, then issues the next cycle.
- Redirect to 0x8000 during PREFETCH → abort, LOAD 0x8000 within 2 cycles. Earlier fills still write their original idx/tag.
- Completion tag 5 and acceptance tag 6 in the same cycle → write for tag 5 and allocate for tag 6, with no loss of either.
- reset=0 with 2 fills outstanding, then their tags return → wr1_en stays 0 and all outputs hold reset values.
